// File: rtl/lcd_pkg.sv
// ============================================================================
// Module   : lcd_pkg
// Brief    : Shared state encoding and command decode for the LCD engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } lcd_state_t;

  localparam logic [7:0] LCD_CMD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME_MASK = 8'hFE;
  localparam logic [7:0] LCD_CMD_HOME      = 8'h02;

  localparam int RS_BIT  = 0;
  localparam int RAW_BIT = 1;

  // Clear and home need the long settle time on the controller.
  function automatic logic is_long_cmd(input logic [7:0] i_byte);
    return (i_byte == LCD_CMD_CLEAR) ||
           ((i_byte & LCD_CMD_HOME_MASK) == LCD_CMD_HOME);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_timer.sv
// ============================================================================
// Module   : lcd_timer
// Brief    : Loadable down-counter; expired flags the last cycle of a phase.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_ce,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  output logic             o_expired
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_ce) begin
      if (i_load) begin
        r_count <= i_value;
      end else if (r_count != '0) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // A load of N yields exactly N cycles before the phase ends.
  assign o_expired = (r_count == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/lcd_cmd_engine.sv
// ============================================================================
// Module   : lcd_cmd_engine
// Brief    : HD44780 command/data writer behind a custom-instruction slot.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_cmd_engine
  import lcd_pkg::*;
#(
  parameter int BUS_WIDTH        = 8,
  parameter int SETUP_CYCLES     = 2000,
  parameter int EN_HIGH_CYCLES   = 100000,
  parameter int HOLD_CYCLES      = 100000,
  parameter int LONG_HOLD_CYCLES = 200000,
  parameter int CNT_W            = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  output logic [31:0] result,
  output logic        done,
  output logic        read_write,
  output logic        register_select,
  output logic        enable_op,
  output logic [7:0]  data_out
);

  localparam logic             c_bus4  = (BUS_WIDTH == 4);
  localparam logic [CNT_W-1:0] c_setup = CNT_W'(SETUP_CYCLES);
  localparam logic [CNT_W-1:0] c_enh   = CNT_W'(EN_HIGH_CYCLES);
  localparam logic [CNT_W-1:0] c_hold  = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] c_lhold = CNT_W'(LONG_HOLD_CYCLES);

  lcd_state_t       r_state, w_state_n;
  logic             r_rs, w_rs_n;
  logic             r_raw, w_raw_n;
  logic             r_second, w_second_n;
  logic [7:0]       r_byte, w_byte_n;
  logic             r_rsel, w_rsel_n;
  logic             r_en, w_en_n;
  logic [7:0]       r_data, w_data_n;
  logic             r_done, w_done_n;
  logic [31:0]      r_result, w_result_n;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_expired;
  logic             w_last;
  logic             w_unused_bits;

  assign w_unused_bits = ^{dataA[31:2], dataB[31:8]};

  lcd_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (reset),
    .i_ce     (clk_en),
    .i_load   (w_load),
    .i_value  (w_load_val),
    .o_expired(w_expired)
  );

  assign w_last = !c_bus4 || r_raw || r_second;

  always_comb begin
    w_state_n  = r_state;
    w_rs_n     = r_rs;
    w_raw_n    = r_raw;
    w_second_n = r_second;
    w_byte_n   = r_byte;
    w_rsel_n   = r_rsel;
    w_en_n     = r_en;
    w_data_n   = r_data;
    w_done_n   = 1'b0;
    w_result_n = r_result;
    w_load     = 1'b0;
    w_load_val = c_setup;
    case (r_state)
      ST_IDLE: begin
        // The done-pulse cycle is still the completion cycle: no new start.
        if (start && !r_done) begin
          w_rs_n     = dataA[RS_BIT];
          w_raw_n    = c_bus4 && dataA[RAW_BIT];
          w_second_n = 1'b0;
          w_byte_n   = dataB[7:0];
          w_rsel_n   = dataA[RS_BIT];
          w_data_n   = c_bus4 ? {dataB[7:4], 4'b0000} : dataB[7:0];
          w_load     = 1'b1;
          w_load_val = c_setup;
          w_state_n  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (w_expired) begin
          w_en_n     = 1'b1;
          w_load     = 1'b1;
          w_load_val = c_enh;
          w_state_n  = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (w_expired) begin
          w_en_n     = 1'b0;
          w_load     = 1'b1;
          w_load_val = (w_last && !r_rs && is_long_cmd(r_byte)) ? c_lhold : c_hold;
          w_state_n  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_expired) begin
          if (!w_last) begin
            w_second_n = 1'b1;
            w_data_n   = {r_byte[3:0], 4'b0000};
            w_load     = 1'b1;
            w_load_val = c_setup;
            w_state_n  = ST_SETUP;
          end else begin
            w_state_n = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_done_n   = 1'b1;
        w_result_n = r_result + 32'd1;
        w_state_n  = ST_IDLE;
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_rs     <= 1'b0;
      r_raw    <= 1'b0;
      r_second <= 1'b0;
      r_byte   <= 8'h00;
      r_rsel   <= 1'b0;
      r_en     <= 1'b0;
      r_data   <= 8'h00;
      r_done   <= 1'b0;
      r_result <= 32'd0;
    end else if (clk_en) begin
      r_state  <= w_state_n;
      r_rs     <= w_rs_n;
      r_raw    <= w_raw_n;
      r_second <= w_second_n;
      r_byte   <= w_byte_n;
      r_rsel   <= w_rsel_n;
      r_en     <= w_en_n;
      r_data   <= w_data_n;
      r_done   <= w_done_n;
      r_result <= w_result_n;
    end
  end

  assign result          = r_result;
  assign done            = r_done;
  assign read_write      = 1'b0;
  assign register_select = r_rsel;
  assign enable_op       = r_en;
  assign data_out        = r_data;

endmodule

`default_nettype wire

// File: tb/tb_lcd_cmd_engine.sv
// ============================================================================
// Module   : tb_lcd_cmd_engine
// Brief    : Scoreboard bench driving an 8-bit and a 4-bit engine in lockstep.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_cmd_engine;

  localparam int S  = 2;
  localparam int E  = 4;
  localparam int H  = 3;
  localparam int LH = 10;

  typedef struct {
    logic [31:0] result;
    int          at;
    int          n;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic        rs;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_en = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dataA = '0;
  logic [31:0] dataB = '0;
  logic [31:0] res  [2];
  logic        dn   [2];
  logic        rw   [2];
  logic        rsel [2];
  logic        en   [2];
  logic [7:0]  dout [2];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int model_cnt = 0;
  exp_t q0[$];
  exp_t q1[$];

  int         pcount [2];
  logic [7:0] pdata  [2][4];
  logic       prs    [2][4];
  int         plen   [2][4];
  int         cur_len[2];
  logic       prev_en[2];
  logic       prev_dn[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_cmd_engine #(.BUS_WIDTH(8), .SETUP_CYCLES(S), .EN_HIGH_CYCLES(E),
                   .HOLD_CYCLES(H), .LONG_HOLD_CYCLES(LH), .CNT_W(32)) u_dut8 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
    .dataA(dataA), .dataB(dataB), .result(res[0]), .done(dn[0]),
    .read_write(rw[0]), .register_select(rsel[0]), .enable_op(en[0]),
    .data_out(dout[0]));

  lcd_cmd_engine #(.BUS_WIDTH(4), .SETUP_CYCLES(S), .EN_HIGH_CYCLES(E),
                   .HOLD_CYCLES(H), .LONG_HOLD_CYCLES(LH), .CNT_W(32)) u_dut4 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
    .dataA(dataA), .dataB(dataB), .result(res[1]), .done(dn[1]),
    .read_write(rw[1]), .register_select(rsel[1]), .enable_op(en[1]),
    .data_out(dout[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  // Expected response from the transfer rules, not from any state sequence.
  function automatic exp_t model(input int bw, input logic rs, input logic raw,
                                 input logic [7:0] b, input int cnt, input int k,
                                 input int stall);
    exp_t e;
    logic lng;
    int   holds;
    e.n      = (bw == 8 || raw) ? 1 : 2;
    e.d0     = (bw == 8) ? b : {b[7:4], 4'h0};
    e.d1     = {b[3:0], 4'h0};
    e.rs     = rs;
    e.result = cnt;
    lng      = !rs && (b >= 8'd1 && b <= 8'd3);
    holds    = (e.n - 1) * H + (lng ? LH : H);
    e.at     = k + 1 + e.n * (S + E) + holds + stall;
    return e;
  endfunction

  task automatic on_done(input int d);
    exp_t e;
    string tag;
    tag = (d == 0) ? "bus8" : "bus4";
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      chk({tag, "_unexpected_done"}, 32'd1, 32'd0);
    end else begin
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      chk({tag, "_result"}, res[d], e.result);
      chk({tag, "_latency"}, cyc, e.at);
      chk({tag, "_pulses"}, pcount[d], e.n);
      chk({tag, "_data0"}, {24'h0, pdata[d][0]}, {24'h0, e.d0});
      chk({tag, "_rs0"}, {31'h0, prs[d][0]}, {31'h0, e.rs});
      chk({tag, "_len0"}, plen[d][0], E);
      if (e.n == 2 && pcount[d] >= 2) begin
        chk({tag, "_data1"}, {24'h0, pdata[d][1]}, {24'h0, e.d1});
        chk({tag, "_len1"}, plen[d][1], E);
      end
      chk({tag, "_rw"}, {31'h0, rw[d]}, 32'h0);
    end
    pcount[d] = 0;
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        pcount[d]  = 0;
        prev_en[d] = 1'b0;
        prev_dn[d] = 1'b0;
      end else begin
        if (en[d] && !prev_en[d]) begin
          if (pcount[d] < 4) begin
            pdata[d][pcount[d]] = dout[d];
            prs[d][pcount[d]]   = rsel[d];
          end
          cur_len[d] = 0;
        end
        if (en[d] && clk_en) cur_len[d]++;
        if (!en[d] && prev_en[d]) begin
          if (pcount[d] < 4) plen[d][pcount[d]] = cur_len[d];
          pcount[d]++;
        end
        if (dn[d] && prev_dn[d] && clk_en)
          chk((d == 0) ? "bus8_done_width" : "bus4_done_width", 32'd2, 32'd1);
        if (dn[d] && !prev_dn[d]) on_done(d);
        prev_en[d] = en[d];
        prev_dn[d] = dn[d];
      end
    end
  end

  // Returns with the sampling edge index in k, #1 after that edge.
  task automatic drive_start(input logic rs, input logic raw, input logic [7:0] b,
                             output int k);
    @(posedge clk); #1;
    dataA = {30'h0, raw, rs};
    dataB = {$urandom_range(0, 255) & 32'hFFFFFF, b} & 32'hFFFF_FFFF;
    dataB[7:0] = b;
    start = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    start = 1'b0;
  endtask

  task automatic issue(input logic rs, input logic raw, input logic [7:0] b,
                       input int stall_at, input int stall_len, output int k);
    drive_start(rs, raw, b, k);
    model_cnt++;
    q0.push_back(model(8, rs, raw, b, model_cnt, k, stall_len));
    q1.push_back(model(4, rs, raw, b, model_cnt, k, stall_len));
    if (stall_len > 0) begin
      repeat (stall_at - 1) @(posedge clk);
      #1 clk_en = 1'b0;
      repeat (stall_len) @(posedge clk);
      #1 clk_en = 1'b1;
    end
  endtask

  task automatic start_at(input int k, input int off);
    while (cyc < k + off - 1) begin @(posedge clk); #1; end
    dataB = {24'h0, 8'h3C};
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 400) begin
      @(posedge clk); t++;
    end
    if (t >= 400) begin
      chk("done_timeout", 32'd0, 32'd1);
      q0.delete(); q1.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int k;
    logic [7:0] b;
    logic [7:0] fixed [7];
    fixed[0] = 8'h41; fixed[1] = 8'h01; fixed[2] = 8'h02;
    fixed[3] = 8'h03; fixed[4] = 8'h04; fixed[5] = 8'hA5; fixed[6] = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_result", res[d], 32'h0);
      chk("reset_outs", {28'h0, dn[d], rw[d], rsel[d], en[d]}, 32'h0);
      chk("reset_data", {24'h0, dout[d]}, 32'h0);
    end
    #1 reset = 1'b0;

    issue(1'b1, 1'b0, 8'h41, 0, 0, k); wait_idle();
    for (int i = 1; i < 7; i++) begin
      issue(1'b0, 1'b0, fixed[i], 0, 0, k); wait_idle();
    end
    issue(1'b1, 1'b0, 8'hA5, 0, 0, k); wait_idle();
    issue(1'b1, 1'b1, 8'hA5, 0, 0, k); wait_idle();
    issue(1'b0, 1'b1, 8'h01, 0, 0, k); wait_idle();
    issue(1'b1, 1'b0, 8'h41, 3, 5, k); wait_idle();

    // Starts while busy and in the completion cycles must not be taken.
    issue(1'b1, 1'b0, 8'h55, 0, 0, k);
    start_at(k, 3);
    start_at(k, 10);
    start_at(k, 11);
    wait_idle();
    repeat (20) @(posedge clk);

    for (int i = 0; i < 25; i++) begin
      b = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 5)) : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0)
        issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), b,
              $urandom_range(1, 5), $urandom_range(1, 6), k);
      else
        issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), b, 0, 0, k);
      wait_idle();
    end

    // Abort mid-pulse.
    drive_start(1'b1, 1'b0, 8'h77, k);
    while (cyc < k + 3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("abort_en", {31'h0, en[d]}, 32'h0);
      chk("abort_data", {24'h0, dout[d]}, 32'h0);
      chk("abort_result", res[d], 32'h0);
      chk("abort_done", {31'h0, dn[d]}, 32'h0);
    end
    #1;
    model_cnt = 0;
    pcount[0] = 0; pcount[1] = 0;
    repeat (30) @(posedge clk);
    issue(1'b1, 1'b0, 8'h41, 0, 0, k); wait_idle();

    chk("queue_empty", q0.size() + q1.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d required=0", cyc);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/lcd_cmd_engine.md
Name: lcd_cmd_engine

Overview:
- Parametrised successor to the single-byte LCD write custom instruction. It drives an HD44780-style character LCD from the Nios II custom-instruction interface.
- Adds a selectable 4-bit/8-bit bus, parametrised setup/enable/hold timing, and a longer hold for clear/home commands.
- Adds an explicit start/done handshake, a raw-nibble mode for the 4-bit init sequence, and a transfer counter returned in result.
- Sits between the CPU custom-instruction slot and the LCD pins.

Parameters:
- BUS_WIDTH, 8, LCD data bus mode: 8 = one transfer per command; 4 = two nibble transfers, high nibble first.
- SETUP_CYCLES, 2000, cycles RS/data are stable with lcd_en low before each pulse (>=1).
- EN_HIGH_CYCLES, 100000, cycles lcd_en is held high per transfer (>=1).
- HOLD_CYCLES, 100000, cycles lcd_en is low after each transfer (>=1).
- LONG_HOLD_CYCLES, 200000, replaces HOLD_CYCLES after the final transfer of a clear (0x01) or home (0x02/0x03) command with RS=0.
- CNT_W, 32, timer width; must hold the largest cycle parameter.

Ports:
- clk in 1 system clock.
- reset in 1 synchronous, active-high reset.
- clk_en in 1 custom-instruction clock enable; when low, all state, timers and outputs freeze.
- start in 1 command request, sampled only in IDLE with clk_en=1.
- dataA in 32: [0]=RS; [1]=raw nibble (4-bit mode only: send dataB[7:4] once); [31:2] ignored.
- dataB in 32: [7:0] command/data byte; [31:8] ignored.
- result out 32: count of completed commands since reset, value after the current one; wraps at 2^32.
- done out 1: one-cycle completion pulse.
- read_write out 1: LCD R/W, constant 0.
- register_select out 1: LCD RS.
- enable_op out 1: LCD E.
- data_out out 8: LCD DB7..DB0. In 4-bit mode the nibble is on [7:4] and [3:0]=0.

Behaviour:
- Reset values: result=0, done=0, read_write=0, register_select=0, enable_op=0, data_out=0, state=IDLE, timer=0.
- Reset mid-operation aborts immediately: enable_op drops to 0 next edge, no done pulse, result is cleared.
- All transitions and timer decrements occur only on edges with clk_en=1.
- IDLE: done=0 except in the DONE cycle. On start, latch RS and byte, drive register_select and data_out (8-bit: byte; 4-bit: {byte[7:4],4'b0}), load timer=SETUP_CYCLES, go to SETUP.
- SETUP: enable_op=0. When the timer expires after exactly SETUP_CYCLES cycles, set enable_op=1, load EN_HIGH_CYCLES, go to PULSE.
- PULSE: enable_op=1 for exactly EN_HIGH_CYCLES cycles, then enable_op=0, load the hold count, go to HOLD.
- Hold count: LONG_HOLD_CYCLES if this is the last transfer of the command AND RS=0 AND byte is in {0x01,0x02,0x03}; otherwise HOLD_CYCLES.
- HOLD end:
  - 4-bit mode, first nibble, raw=0: drive {byte[3:0],4'b0}, load SETUP_CYCLES, go to SETUP.
  - Otherwise go to DONE.
- DONE: done=1 for one cycle, result increments, return to IDLE. A start in this cycle is ignored; a new start is accepted from the next IDLE cycle.
- In 8-bit mode the raw bit is ignored.
- start outside IDLE is ignored; there is no queueing.
- register_select and data_out hold their last values in IDLE.
- Latency with clk_en continuously high, start sampled at edge k: done is high in the cycle after edge k+1+N*(S+E)+sum(holds), where N is the number of transfers (1 or 2).

Decomposition:
- Package lcd_pkg holds:
  - state encoding (IDLE, SETUP, PULSE, HOLD, DONE);
  - LCD_CMD_CLEAR=8'h01 and LCD_CMD_HOME_MASK=8'hFE/8'h02 for the long-hold decode;
  - dataA bit indices RS_BIT=0 and RAW_BIT=1.
- Sub-module lcd_timer (CNT_W): loadable down-counter with load/value inputs, a clk_en gate, and an expired flag. The main FSM instantiates one.

Test Plan:
Test parameters: S=2, E=4, H=3, LH=10, clk_en=1 unless stated.
- 8-bit write: start, dataA=1, dataB=0x41 -> register_select=1; data_out=0x41; enable_op high 4 cycles after 2 setup; done pulse 1 cycle at k+10; result=1.
- 8-bit clear: dataA=0, dataB=0x01 -> same pulse shape but hold=10 cycles; done at k+17; result increments. Repeat with 0x02/0x03 (long hold) and with 0x04 (short hold).
- 4-bit mode, dataB=0xA5, RS=1 -> two enable pulses. data_out=0xA0 during the first and 0x50 during the second. done at k+19. With raw=1, a single pulse with 0xA0 and done at k+10.
- clk_en stall: drop clk_en for 5 cycles mid-PULSE -> enable_op stays high, timer frozen; total pulse = 4 enabled cycles; done is delayed by exactly 5.
- Start during busy and in the DONE cycle -> ignored; no extra pulses; result increments once.
- Reset asserted mid-PULSE -> next edge: enable_op=0, data_out=0, result=0, no done pulse. A subsequent start completes normally with result=1.
